psum_writeback: RTL and testbench
=================================

Name: psum_writeback

Overview:
- Consumer end of the partial-sum result stream: takes the finished `result` / `result_valid` sums that drain from the psum register file.
- Requantizes each sum to OWIDTH bits, packs PACK lanes per output word and buffers the words in a word FIFO.
- Writes the words to the output feature-map buffer through a valid/ready write port, generating sequential addresses.
- Counts output channels and pulses `done` when the configured layer tile has been written.

Parameters:
- DWIDTH, 32, width of the incoming signed sum.
- OWIDTH, 8, width of one requantized lane.
- PACK, 4, lanes per output word.
- AWIDTH, 4, word FIFO depth = 2^AWIDTH.
- ADDR_W, 12, output buffer word-address width.

Ports:
- clk  input  1  clock
- rstn  input  1  reset, asynchronous, active-low
- cfg_start  input  1  one-cycle start pulse; cfg_* sampled here
- cfg_base_addr  input  ADDR_W  first word address
- cfg_pix_per_oc  input  16  results per output channel, >=1
- cfg_num_oc  input  16  output channels in tile, >=1
- cfg_shift  input  5  arithmetic right shift for requant
- result_valid  input  1  sum valid; no backpressure
- result  input  DWIDTH  signed sum
- wr_valid  output  1  write word available
- wr_ready  input  1  buffer accepts word
- wr_addr  output  ADDR_W  word address
- wr_data  output  OWIDTH*PACK  packed lanes; lane 0 in LSBs
- busy  output  1  high in RUN/FLUSH
- done  output  1  one-cycle completion pulse
- overflow  output  1  sticky; a word was dropped because the FIFO was full

Behaviour:
- Reset values: wr_valid=0, wr_addr=0, wr_data=0, busy=0, done=0, overflow=0. All counters are cleared, the FIFO is emptied and the FSM goes to IDLE.
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE -> RUN on cfg_start. Latches cfg_*, sets the address counter to cfg_base_addr and clears overflow.
  - RUN -> FLUSH when the last result of the last channel has been packed.
  - FLUSH -> DONE when the FIFO is empty and no write is pending.
  - DONE -> IDLE unconditionally after 1 cycle; done=1 only in DONE.
- cfg_start outside IDLE is ignored. result_valid outside RUN is ignored; no state changes.
- Requant stage, registered with 1-cycle latency:
  - v = (result + (cfg_shift ? 1<<(cfg_shift-1) : 0)) >>> cfg_shift, computed at DWIDTH+1 bits so the rounding add cannot overflow.
  - v is then saturated to signed OWIDTH: [-128, 127] for OWIDTH=8.
- Packer:
  - Lane index increments per requantized sample.
  - The word is pushed when lane PACK-1 is filled, or when the per-channel pixel count reaches cfg_pix_per_oc.
  - On a channel-end push, unfilled upper lanes are zero. The lane index and pixel count reset, and the channel count increments.
  - Every channel therefore starts at lane 0 of a fresh word.
- Word FIFO:
  - First-word-fall-through: wr_valid = ~empty; wr_data/wr_addr show the head entry.
  - Each entry stores its address. The address counter increments by 1 per push and wraps modulo 2^ADDR_W.
  - A pop occurs on wr_valid & wr_ready.
  - wr_valid/wr_data/wr_addr stay stable while wr_valid & ~wr_ready.
- Latency: a result_valid that completes a word produces wr_valid 2 cycles later (requant reg + FIFO write) when the FIFO was empty.
- Simultaneous push and pop with the FIFO full: the pop frees a slot and the push succeeds.
- Push with the FIFO full and no pop: the word is dropped and overflow is set. The address counter still advances, so later words keep their correct addresses.
- Back-to-back result_valid every cycle is supported indefinitely while wr_ready=1.
- Asynchronous reset mid-operation discards all buffered words and returns to IDLE; no done pulse is produced.

Optional Feature:
- PSUM_WB_RELU_EN
  - Defined: after saturation, negative lanes are clamped to 0, giving output range [0, 2^(OWIDTH-1)-1].
  - Undefined: signed saturation only.
  - Packing, latency and handshake are identical in both builds.

Test Plan:
- Nominal: start with base=0x010, pix=8, oc=2, shift=0, wr_ready=1; results 1..16 every cycle -> 4 words. Addr 0x010 carries lanes {4,3,2,1}, and so on up to 0x013 with {16,15,14,13}. done pulses once, 1 cycle after the last pop; overflow=0.
- Channel tail padding: pix=5, oc=2; results 1..10 -> 4 words at base..base+3. Word 1 = {0,0,0,5}, word 3 = {0,0,0,10}.
- Requant/saturation: shift=4; inputs 24, 23, -24, 100000, -100000.
  - Without macro -> lanes 2, 1, -1, 127, -128.
  - With PSUM_WB_RELU_EN -> lanes 2, 1, 0, 127, 0.
- Backpressure/overflow: AWIDTH=4, wr_ready=0; 80 results (20 words).
  - First 16 words are held with wr_addr stable and overflow=1 after word 17.
  - On releasing wr_ready, 16 words drain at base..base+15.
- Address wrap: base=0xFFE, pix=12, oc=1 -> 3 words at 0xFFE, 0xFFF, 0x000.
- Reset mid-run: assert rstn low after 6 results -> all outputs 0 next edge. A new start with oc=1, pix=4 then completes normally at the new base.

Source files
------------

// File: rtl/psum_writeback.sv
// psum_writeback: requantizes finished partial sums, packs lanes into words
// and writes them out through a FIFO. Build macro PSUM_WB_RELU_EN adds ReLU.

module psum_writeback #(
    parameter int DWIDTH = 32,
    parameter int OWIDTH = 8,
    parameter int PACK   = 4,
    parameter int AWIDTH = 4,
    parameter int ADDR_W = 12
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   cfg_start,
    input  logic [ADDR_W-1:0]      cfg_base_addr,
    input  logic [15:0]            cfg_pix_per_oc,
    input  logic [15:0]            cfg_num_oc,
    input  logic [4:0]             cfg_shift,
    input  logic                   result_valid,
    input  logic [DWIDTH-1:0]      result,
    output logic                   wr_valid,
    input  logic                   wr_ready,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [OWIDTH*PACK-1:0] wr_data,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow
);

    localparam int DEPTH = 1 << AWIDTH;
    localparam int WW    = OWIDTH * PACK;
    localparam int LW    = (PACK > 1) ? $clog2(PACK) : 1;
    localparam logic signed [DWIDTH:0] SMAX =
        {{(DWIDTH-OWIDTH+2){1'b0}}, {(OWIDTH-1){1'b1}}};
    localparam logic signed [DWIDTH:0] SMIN =
        {{(DWIDTH-OWIDTH+2){1'b1}}, {(OWIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t state_q, state_d;

    logic [15:0]        pix_q, oc_q;
    logic [4:0]         shift_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               ovf_q;

    logic               rq_valid_q;
    logic [OWIDTH-1:0]  rq_data_q;
    logic [OWIDTH-1:0]  lane_w;
    logic signed [DWIDTH:0] ext, rnd, shv;

    logic [LW-1:0]      lane_q, lane_d;
    logic [15:0]        pix_cnt_q, pix_d;
    logic [15:0]        oc_cnt_q, oc_d;
    logic [WW-1:0]      pack_q, pack_d, word_w;
    logic               take, push, pix_last, oc_last, lane_last;

    logic [WW-1:0]      dmem [DEPTH];
    logic [ADDR_W-1:0]  amem [DEPTH];
    logic [AWIDTH:0]    wptr_q, rptr_q;
    logic               empty, full, pop, wr_en;

    logic start_go;
    assign start_go = (state_q == IDLE) & cfg_start;

    // Round-half-up arithmetic shift at DWIDTH+1 bits, then saturate.
    always_comb begin
        ext = {result[DWIDTH-1], result};
        rnd = '0;
        if (shift_q != 5'd0)
            rnd = {{DWIDTH{1'b0}}, 1'b1} << (shift_q - 5'd1);
        shv = (ext + rnd) >>> shift_q;
        if (shv > SMAX)
            lane_w = SMAX[OWIDTH-1:0];
        else if (shv < SMIN)
            lane_w = SMIN[OWIDTH-1:0];
        else
            lane_w = shv[OWIDTH-1:0];
`ifdef PSUM_WB_RELU_EN
        if (lane_w[OWIDTH-1])
            lane_w = '0;
`else
`endif
    end

    // Requant pipeline register; sums only count while running.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rq_valid_q <= 1'b0;
            rq_data_q  <= '0;
        end else begin
            rq_valid_q <= (state_q == RUN) & result_valid;
            rq_data_q  <= lane_w;
        end
    end

    assign take      = (state_q == RUN) & rq_valid_q;
    assign pix_last  = pix_cnt_q == pix_q - 16'd1;
    assign oc_last   = oc_cnt_q == oc_q - 16'd1;
    assign lane_last = lane_q == LW'(PACK - 1);
    assign push      = take & (pix_last | lane_last);

    // Packer: drop the sample into its lane; emit on full word or channel end.
    always_comb begin
        word_w = pack_q;
        for (int i = 0; i < PACK; i++)
            if (lane_q == LW'(i))
                word_w[i*OWIDTH +: OWIDTH] = rq_data_q;
        pack_d = pack_q;
        lane_d = lane_q;
        pix_d  = pix_cnt_q;
        oc_d   = oc_cnt_q;
        if (take) begin
            if (push) begin
                pack_d = '0;
                lane_d = '0;
            end else begin
                pack_d = word_w;
                lane_d = lane_q + LW'(1);
            end
            if (pix_last) begin
                pix_d = '0;
                oc_d  = oc_cnt_q + 16'd1;
            end else begin
                pix_d = pix_cnt_q + 16'd1;
            end
        end
    end

    // Config latch, packer counters, address counter and sticky overflow.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pix_q     <= '0;
            oc_q      <= '0;
            shift_q   <= '0;
            addr_q    <= '0;
            ovf_q     <= 1'b0;
            lane_q    <= '0;
            pix_cnt_q <= '0;
            oc_cnt_q  <= '0;
            pack_q    <= '0;
        end else if (start_go) begin
            pix_q     <= cfg_pix_per_oc;
            oc_q      <= cfg_num_oc;
            shift_q   <= cfg_shift;
            addr_q    <= cfg_base_addr;
            ovf_q     <= 1'b0;
            lane_q    <= '0;
            pix_cnt_q <= '0;
            oc_cnt_q  <= '0;
            pack_q    <= '0;
        end else begin
            lane_q    <= lane_d;
            pix_cnt_q <= pix_d;
            oc_cnt_q  <= oc_d;
            pack_q    <= pack_d;
            if (push)
                addr_q <= addr_q + ADDR_W'(1);
            if (push & full & ~pop)
                ovf_q <= 1'b1;
        end
    end

    assign empty = wptr_q == rptr_q;
    assign full  = (wptr_q[AWIDTH] != rptr_q[AWIDTH]) &&
                   (wptr_q[AWIDTH-1:0] == rptr_q[AWIDTH-1:0]);
    assign pop   = ~empty & wr_ready;
    assign wr_en = push & (~full | pop);

    // Word FIFO pointers; an extra wrap bit separates full from empty.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (wr_en)
                wptr_q <= wptr_q + 1'b1;
            if (pop)
                rptr_q <= rptr_q + 1'b1;
        end
    end

    // FIFO storage needs no reset; outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            dmem[wptr_q[AWIDTH-1:0]] <= word_w;
            amem[wptr_q[AWIDTH-1:0]] <= addr_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (cfg_start) state_d = RUN;
            RUN:   if (take & pix_last & oc_last) state_d = FLUSH;
            FLUSH: if (empty) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign wr_valid = ~empty;
    assign wr_data  = empty ? '0 : dmem[rptr_q[AWIDTH-1:0]];
    assign wr_addr  = empty ? '0 : amem[rptr_q[AWIDTH-1:0]];
    assign busy     = (state_q == RUN) | (state_q == FLUSH);
    assign done     = state_q == DONE;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_psum_writeback.sv
// Randomized scoreboard bench for psum_writeback.
// Expected words come from a lane/word reference model of the result stream.

module tb_psum_writeback;

    localparam int DW = 32;
    localparam int OW = 8;
    localparam int PK = 4;
    localparam int AD = 12;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          cfg_start = 1'b0;
    logic [AD-1:0] cfg_base_addr = '0;
    logic [15:0]   cfg_pix_per_oc = 16'd1;
    logic [15:0]   cfg_num_oc = 16'd1;
    logic [4:0]    cfg_shift = '0;
    logic          result_valid = 1'b0;
    logic [DW-1:0] result = '0;
    logic          wr_valid;
    logic          wr_ready = 1'b1;
    logic [AD-1:0] wr_addr;
    logic [OW*PK-1:0] wr_data;
    logic          busy, done, overflow;

    always #5 clk = ~clk;

    psum_writeback dut (
        .clk(clk), .rstn(rstn), .cfg_start(cfg_start),
        .cfg_base_addr(cfg_base_addr), .cfg_pix_per_oc(cfg_pix_per_oc),
        .cfg_num_oc(cfg_num_oc), .cfg_shift(cfg_shift),
        .result_valid(result_valid), .result(result),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy), .done(done), .overflow(overflow)
    );

    typedef struct packed {
        logic [AD-1:0]    a;
        logic [OW*PK-1:0] d;
    } word_t;

    word_t sb[$];
    int    res_q[$];
    int    n_vec = 0, n_fail = 0;
    int    cyc = 0, done_cnt = 0, done_cyc = -10, last_pop_cyc = -10;
    int    rmode = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    function automatic logic [OW-1:0] rq(input int r, input int s);
        longint v;
        v = longint'(r);
        if (s > 0) v = v + (longint'(1) << (s - 1));
        v = v >>> s;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
`ifdef PSUM_WB_RELU_EN
        if (v < 0) v = 0;
`else
`endif
        return v[OW-1:0];
    endfunction

    task automatic build_expect(input logic [AD-1:0] base, input int pix,
                                input int oc, input int sh, input int cap);
        int w = 0;
        int idx = 0;
        logic [OW*PK-1:0] wd;
        for (int c = 0; c < oc; c++) begin
            wd = '0;
            for (int p = 0; p < pix; p++) begin
                int r = (idx < res_q.size()) ? res_q[idx] : 0;
                idx++;
                wd[(p % PK)*OW +: OW] = rq(r, sh);
                if (p % PK == PK - 1 || p == pix - 1) begin
                    if (w < cap) sb.push_back('{a: AD'(base + w), d: wd});
                    w++;
                    wd = '0;
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        case (rmode)
            0: wr_ready = 1'b1;
            1: wr_ready = 1'($urandom_range(0, 1));
            default: wr_ready = 1'b0;
        endcase
    end

    initial forever begin
        @(negedge clk);
        if (rstn) begin
            if (wr_valid) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_word: got addr %h data %h, required none",
                             wr_addr, wr_data);
                end else begin
                    chk("head_word", {wr_addr, wr_data}, {sb[0].a, sb[0].d});
                    if (wr_ready) void'(sb.pop_front());
                end
                if (wr_ready) last_pop_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic start(input logic [AD-1:0] base, input int pix,
                         input int oc, input int sh);
        @(posedge clk);
        #1;
        cfg_base_addr  = base;
        cfg_pix_per_oc = 16'(pix);
        cfg_num_oc     = 16'(oc);
        cfg_shift      = 5'(sh);
        cfg_start      = 1'b1;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
    endtask

    task automatic feed(input bit gap, input bit inj, input int ovc);
        for (int k = 0; k < res_q.size(); k++) begin
            if (gap) begin
                int g = int'($urandom_range(0, 2));
                result_valid = 1'b0;
                cfg_start = 1'b0;
                repeat (g) begin
                    @(posedge clk);
                    #1;
                end
            end
            result_valid = 1'b1;
            result = res_q[k];
            if (inj && k == 4) begin
                cfg_start = 1'b1;
                cfg_base_addr = 12'h3AA;
            end else begin
                cfg_start = 1'b0;
            end
            if (ovc > 0 && (k + 1 == ovc || k + 1 == ovc + 1)) begin
                @(negedge clk);
                chk("overflow_step", overflow, (k + 1 == ovc + 1) ? 1 : 0);
            end
            @(posedge clk);
            #1;
        end
        result_valid = 1'b0;
        cfg_start = 1'b0;
    endtask

    task automatic run_test(input logic [AD-1:0] base, input int pix,
                            input int oc, input int sh, input int rm,
                            input bit gap, input int cap, input int ovc,
                            input int ovf_exp, input bit inj);
        int d0;
        bit got;
        build_expect(base, pix, oc, sh, cap);
        rmode = rm;
        d0 = done_cnt;
        start(base, pix, oc, sh);
        feed(gap, inj, ovc);
        if (rm == 2) begin
            repeat (4) @(posedge clk);
            @(negedge clk);
            chk("held_valid", wr_valid, 1);
            chk("held_addr", wr_addr, base);
            rmode = 0;
        end
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            #1;
            got = done_cnt != d0;
        end
        if (!got) begin
            n_vec++;
            n_fail++;
            $display("FAIL done_timeout: got no done, required one pulse");
            sb.delete();
        end else begin
            chk("busy_in_done", busy, 0);
            chk("done_after_pop", done_cyc - last_pop_cyc, 2);
            chk("overflow_end", overflow, ovf_exp);
            chk("words_left", sb.size(), 0);
            repeat (3) @(negedge clk);
            chk("single_done", done_cnt - d0, 1);
        end
        @(posedge clk);
        #1;
        result_valid = 1'b1;
        result = 32'd77;
        repeat (3) @(posedge clk);
        #1;
        result_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("idle_ignore", {wr_valid, busy, done}, 0);
        res_q.delete();
    endtask

    function automatic int rnd_res();
        if ($urandom_range(0, 1) == 1) return int'($urandom);
        return int'($urandom_range(0, 4000)) - 2000;
    endfunction

    initial begin
        int d0;
        #12;
        chk("reset_outputs", {wr_valid, wr_addr, wr_data, busy, done, overflow}, 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        for (int i = 1; i <= 16; i++) res_q.push_back(i);
        run_test(12'h010, 8, 2, 0, 0, 0, 1000, 0, 0, 1);

        for (int i = 1; i <= 10; i++) res_q.push_back(i);
        run_test(12'h020, 5, 2, 0, 0, 0, 1000, 0, 0, 0);

        res_q = '{24, 23, -24, 100000, -100000};
        run_test(12'h030, 5, 1, 4, 0, 0, 1000, 0, 0, 0);

        for (int i = 0; i < 12; i++) res_q.push_back(rnd_res());
        run_test(12'hFFE, 12, 1, 2, 0, 0, 1000, 0, 0, 0);

        for (int t = 0; t < 6; t++) begin
            int pix = int'($urandom_range(4, 20));
            int oc  = int'($urandom_range(1, 4));
            for (int i = 0; i < pix * oc; i++) res_q.push_back(rnd_res());
            run_test(AD'($urandom), pix, oc, int'($urandom_range(0, 12)),
                     1, 1, 1000, 0, 0, 0);
        end

        for (int i = 0; i < 80; i++) res_q.push_back(int'($urandom_range(0, 200)) - 100);
        run_test(12'h100, 80, 1, 0, 2, 0, 16, 69, 1, 0);

        d0 = done_cnt;
        for (int i = 0; i < 6; i++) res_q.push_back(int'($urandom_range(0, 100)));
        build_expect(12'h200, 20, 1, 0, 1);
        rmode = 2;
        start(12'h200, 20, 1, 0);
        feed(0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pre_reset_valid", wr_valid, 1);
        #2;
        rstn = 1'b0;
        #1;
        chk("reset_async", {wr_valid, wr_addr, wr_data, busy, done, overflow}, 0);
        @(posedge clk);
        @(negedge clk);
        chk("reset_held", {wr_valid, wr_addr, wr_data, busy, done, overflow}, 0);
        sb.delete();
        res_q.delete();
        rmode = 0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        chk("no_done_on_reset", done_cnt - d0, 0);
        res_q = '{5, -7, 300, 9};
        run_test(12'h055, 4, 1, 0, 0, 0, 1000, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
